// File: rtl/hex_display_ctrl_if.sv
// Avalon-MM style register bus for the hex display controller.
interface hex_display_ctrl_if;
    logic [1:0]  avs_address;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic        avs_read;
    logic [31:0] avs_readdata;

    modport master (
        output avs_address,
        output avs_write,
        output avs_writedata,
        output avs_read,
        input  avs_readdata
    );

    modport slave (
        input  avs_address,
        input  avs_write,
        input  avs_writedata,
        input  avs_read,
        output avs_readdata
    );
endinterface

// File: rtl/hex_display_ctrl.sv
// Memory-mapped multi-digit 7-segment driver with blanking, blinking and an
// optional auto-incrementing counter driven by a prescaled tick.
module hex_display_ctrl #(
    parameter int unsigned NUM_DIGITS = 6,
    parameter int unsigned TICK_DIV   = 25_000_000,
    parameter bit          ACTIVE_LOW = 1'b1
) (
    input  logic                    clk_clk,
    input  logic                    reset_reset_n,
    hex_display_ctrl_if.slave       avs,
    output logic [7*NUM_DIGITS-1:0] hex_out
);

    localparam int unsigned DW = 4 * NUM_DIGITS;
    localparam int unsigned PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [6:0] DARK = ACTIVE_LOW ? 7'h7F : 7'h00;

    localparam logic [1:0] ADDR_DATA  = 2'd0;
    localparam logic [1:0] ADDR_BLANK = 2'd1;
    localparam logic [1:0] ADDR_BLINK = 2'd2;
    localparam logic [1:0] ADDR_CTRL  = 2'd3;

    logic [DW-1:0]           data_q, data_d;
    logic [NUM_DIGITS-1:0]   blank_q, blank_d;
    logic [NUM_DIGITS-1:0]   blink_q, blink_d;
    logic                    en_q, en_d;
    logic                    count_q, count_d;
    logic                    phase_q, phase_d;
    logic [PW-1:0]           presc_q, presc_d;
    logic [31:0]             rdata_q, rdata_d;
    logic [7*NUM_DIGITS-1:0] hex_q, hex_d;
    logic                    tick;
    logic                    unused_wdata;

    // Upper write-data bits are unimplemented for narrow configurations.
    assign unused_wdata = ^avs.avs_writedata;

    assign tick             = en_q && (presc_q == PRESC_MAX);
    assign avs.avs_readdata = rdata_q;
    assign hex_out          = hex_q;

    // Active-high glyph, bit0 = segment a.
    function automatic logic [6:0] glyph(input logic [3:0] n);
        logic [6:0] g;
        g = 7'b0000000;
        case (n)
            4'h0: g = 7'b0111111;
            4'h1: g = 7'b0000110;
            4'h2: g = 7'b1011011;
            4'h3: g = 7'b1001111;
            4'h4: g = 7'b1100110;
            4'h5: g = 7'b1101101;
            4'h6: g = 7'b1111101;
            4'h7: g = 7'b0000111;
            4'h8: g = 7'b1111111;
            4'h9: g = 7'b1101111;
            4'hA: g = 7'b1110111;
            4'hB: g = 7'b1111100;
            4'hC: g = 7'b0111001;
            4'hD: g = 7'b1011110;
            4'hE: g = 7'b1111001;
            4'hF: g = 7'b1110001;
        endcase
        return g;
    endfunction

    // Register file, prescaler and phase next-state; bus writes beat ticks.
    always_comb begin
        data_d  = data_q;
        blank_d = blank_q;
        blink_d = blink_q;
        en_d    = en_q;
        count_d = count_q;
        phase_d = phase_q;
        presc_d = presc_q;

        if (!en_q) begin
            presc_d = '0;
        end else if (tick) begin
            presc_d = '0;
            phase_d = ~phase_q;
        end else begin
            presc_d = presc_q + 1'b1;
        end

        if (count_q && tick) begin
            data_d = data_q + DW'(1);
        end

        if (avs.avs_write) begin
            case (avs.avs_address)
                ADDR_DATA:  data_d  = avs.avs_writedata[DW-1:0];
                ADDR_BLANK: blank_d = avs.avs_writedata[NUM_DIGITS-1:0];
                ADDR_BLINK: blink_d = avs.avs_writedata[NUM_DIGITS-1:0];
                ADDR_CTRL: begin
                    en_d    = avs.avs_writedata[0];
                    count_d = avs.avs_writedata[1];
                end
            endcase
        end
    end

    // Read mux samples pre-write state, so a same-cycle write is not visible.
    always_comb begin
        rdata_d = rdata_q;
        if (avs.avs_read) begin
            rdata_d = '0;
            case (avs.avs_address)
                ADDR_DATA:  rdata_d[DW-1:0]         = data_q;
                ADDR_BLANK: rdata_d[NUM_DIGITS-1:0] = blank_q;
                ADDR_BLINK: rdata_d[NUM_DIGITS-1:0] = blink_q;
                ADDR_CTRL: begin
                    rdata_d[0] = en_q;
                    rdata_d[1] = count_q;
                    rdata_d[8] = phase_q;
                end
            endcase
        end
    end

    // Segment decode with dark override per digit.
    always_comb begin
        logic [6:0] seg;
        seg   = '0;
        hex_d = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            seg = glyph(data_q[4*k +: 4]);
            if (!en_q || blank_q[k] || (blink_q[k] && phase_q)) begin
                seg = '0;
            end
            hex_d[7*k +: 7] = ACTIVE_LOW ? ~seg : seg;
        end
    end

    // State registers; display resets dark.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            data_q  <= '0;
            blank_q <= '0;
            blink_q <= '0;
            en_q    <= 1'b0;
            count_q <= 1'b0;
            phase_q <= 1'b0;
            presc_q <= '0;
            rdata_q <= '0;
            hex_q   <= {NUM_DIGITS{DARK}};
        end else begin
            data_q  <= data_d;
            blank_q <= blank_d;
            blink_q <= blink_d;
            en_q    <= en_d;
            count_q <= count_d;
            phase_q <= phase_d;
            presc_q <= presc_d;
            rdata_q <= rdata_d;
            hex_q   <= hex_d;
        end
    end

endmodule
